// File: rtl/ir_encoder.sv
// NEC-format IR transmitter: serialises a 32-bit word LSB first as an active-low
// pulse-distance frame. Define IR_CARRIER_EN to modulate marks with a square-wave carrier.
module ir_encoder #(
    parameter int UNIT_CYCLES  = 56,
    parameter int CARRIER_HALF = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        ir_out,
    output logic        busy,
    output logic        done
);

    if (UNIT_CYCLES < 2) begin : g_unit_check
        $error("ir_encoder: UNIT_CYCLES must be >= 2");
    end
    if (CARRIER_HALF < 1) begin : g_carrier_check
        $error("ir_encoder: CARRIER_HALF must be >= 1");
    end

    // The longest state (leader mark) sets the width of the shared duration counter.
    localparam int CNT_W = $clog2(16 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_1U  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_3U  = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_8U  = CNT_W'(8 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_16U = CNT_W'(16 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [31:0]      shift_reg, shift_next;
    logic             ir_reg, ir_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             cnt_zero;
    logic             mark_next;
    logic             state_change;

    assign cnt_zero     = (cnt_reg == '0);
    assign mark_next    = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                          (state_next == STOP_MARK);
    assign state_change = (state_next != state_reg);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = LEAD_MARK;
                    cnt_next     = LOAD_16U;
                    shift_next   = data_in;
                    bit_cnt_next = '0;
                    busy_next    = 1'b1;
                end
            end
            LEAD_MARK: begin
                if (cnt_zero) begin
                    state_next = LEAD_SPACE;
                    cnt_next   = LOAD_8U;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            LEAD_SPACE: begin
                if (cnt_zero) begin
                    state_next = BIT_MARK;
                    cnt_next   = LOAD_1U;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            BIT_MARK: begin
                if (cnt_zero) begin
                    state_next = BIT_SPACE;
                    cnt_next   = shift_reg[0] ? LOAD_3U : LOAD_1U;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            BIT_SPACE: begin
                if (cnt_zero) begin
                    shift_next = {1'b0, shift_reg[31:1]};
                    cnt_next   = LOAD_1U;
                    if (bit_cnt_reg == 5'd31) begin
                        state_next = STOP_MARK;
                    end else begin
                        state_next   = BIT_MARK;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            STOP_MARK: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

`ifdef IR_CARRIER_EN
    localparam int CAR_W = $clog2(CARRIER_HALF + 1);
    localparam logic [CAR_W-1:0] CAR_LOAD = CAR_W'(CARRIER_HALF - 1);

    logic [CAR_W-1:0] car_cnt_reg, car_cnt_next;
    logic             car_lvl_reg, car_lvl_next;

    // Phase restarts low on every mark entry; outside marks it stays parked.
    always_comb begin
        car_cnt_next = car_cnt_reg;
        car_lvl_next = car_lvl_reg;
        if (!mark_next || state_change) begin
            car_cnt_next = CAR_LOAD;
            car_lvl_next = 1'b0;
        end else if (car_cnt_reg == '0) begin
            car_cnt_next = CAR_LOAD;
            car_lvl_next = ~car_lvl_reg;
        end else begin
            car_cnt_next = car_cnt_reg - CAR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            car_cnt_reg <= '0;
            car_lvl_reg <= 1'b0;
        end else begin
            car_cnt_reg <= car_cnt_next;
            car_lvl_reg <= car_lvl_next;
        end
    end

    assign ir_next = mark_next ? car_lvl_next : 1'b1;
`else
    logic unused_change;
    assign unused_change = state_change;
    assign ir_next       = ~mark_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ir_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ir_reg      <= ir_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign ir_out = ir_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_ir_encoder.sv
// Randomised scoreboard bench for ir_encoder: a frame-level model queues expected
// mark/space widths and busy lengths; a negedge monitor measures the waveform.
module tb_ir_encoder;

    localparam int U = 56;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic        ir_out;
    logic        busy;
    logic        done;

    ir_encoder #(.UNIT_CYCLES(U), .CARRIER_HALF(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .ir_out  (ir_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Expected segments encoded as {level, width[30:0]}
    logic [31:0] seg_q[$];
    int          len_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // Frame model straight from the NEC rules: leader, 32 LSB-first bits, stop mark.
    task automatic push_model(input logic [31:0] d);
        int ones;
        seg_q.push_back({1'b0, 31'(16 * U)});
        seg_q.push_back({1'b1, 31'(8 * U)});
        for (int i = 0; i < 32; i++) begin
            seg_q.push_back({1'b0, 31'(U)});
            seg_q.push_back({1'b1, 31'(d[i] ? 3 * U : U)});
        end
        seg_q.push_back({1'b0, 31'(U)});
        ones = $countones(d);
        len_q.push_back(U * (25 + 2 * (32 - ones) + 4 * ones));
        $display("issue frame data=0x%08h expected_busy=%0d", d, len_q[$]);
    endtask

    // ---------------- monitor ----------------
    logic seg_active = 1'b0;
    logic seg_lvl    = 1'b1;
    int   seg_len    = 0;
    int   seg_idx    = 0;
    int   busy_cnt   = 0;
    logic prev_done  = 1'b0;

    task automatic close_seg();
        logic [31:0] e;
        if (seg_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL seg_extra: got level %0d width %0d, none expected", seg_lvl, seg_len);
        end else begin
            e = seg_q.pop_front();
            chk_cnt++;
            if (e[31] === seg_lvl && e[30:0] == 31'(seg_len)) pass_cnt++;
            else $display("FAIL seg[%0d]: got level %0d width %0d want level %0d width %0d",
                          seg_idx, seg_lvl, seg_len, e[31], e[30:0]);
        end
        seg_idx++;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            seg_active = 1'b0;
            busy_cnt   = 0;
            seg_q.delete();
            len_q.delete();
        end else begin
            if (busy) begin
                busy_cnt++;
                if (seg_active && ir_out == seg_lvl) begin
                    seg_len++;
                end else begin
                    if (seg_active) close_seg();
                    seg_active = 1'b1;
                    seg_lvl    = ir_out;
                    seg_len    = 1;
                end
            end else if (seg_active) begin
                close_seg();
                seg_active = 1'b0;
            end
            if (done) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("done_busy_low", {31'd0, busy}, 32'd0);
                check("done_ir_idle", {31'd0, ir_out}, 32'd1);
                if (len_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL done_unexpected: busy_cycles %0d, no frame outstanding", busy_cnt);
                end else begin
                    check("busy_len", 32'(busy_cnt), 32'(len_q.pop_front()));
                end
                busy_cnt = 0;
            end
        end
        prev_done = done;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int n = 0; n < 12000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            chk_cnt++;
            $display("FAIL %s_timeout: no done within 12000 cycles", tag);
        end
    endtask

    task automatic start_frame(input logic [31:0] d);
        push_model(d);
        @(posedge clk); #1;
        start   = 1'b1;
        data_in = d;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = $urandom;
    endtask

    task automatic abort_after(input logic [31:0] d, input int cycles, input string tag);
        start_frame(d);
        repeat (cycles - 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ir"}, {31'd0, ir_out}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        $display("abort %s after %0d cycles", tag, cycles);
    endtask

    initial begin
        logic [31:0] d1, d2, d;
        int t;
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        repeat (10) begin
            @(negedge clk);
            check("rst_ir", {31'd0, ir_out}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        start_frame(32'h0000_0001);
        wait_done("f_one");
        start_frame(32'hCC33_55AA);
        wait_done("f_cc33");

        // Back-to-back with start held and data_in changed while busy
        d1 = $urandom;
        d2 = $urandom;
        push_model(d1);
        @(posedge clk); #1;
        start   = 1'b1;
        data_in = d1;
        @(posedge clk); #1;
        data_in = d2;
        push_model(d2);
        wait_done("b2b_first");
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("b2b_gap_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_second");

        // Abort mid leader space, then mid bit 17
        abort_after($urandom, 20 * U, "abort_lead");
        start_frame($urandom);
        wait_done("post_abort1");
        d = $urandom;
        t = 24 * U;
        for (int i = 0; i < 17; i++) t += U + (d[i] ? 3 * U : U);
        t += U / 2;
        abort_after(d, t, "abort_bit17");
        start_frame($urandom);
        wait_done("post_abort2");

        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            start_frame($urandom);
            wait_done("rand");
        end

        repeat (5) @(negedge clk);
        check("seg_q_empty", 32'(seg_q.size()), 32'd0);
        check("len_q_empty", 32'(len_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ir_encoder.md
Name: ir_encoder

Overview:
NEC-format IR transmitter. It is the transmit counterpart of ir_decoder: it serialises a 32-bit word into the active-low pulse-distance waveform that ir_decoder consumes. The host side is a simple start/busy/done handshake. The output drives the IR LED driver, or ir_decoder's ir_signal in loopback benches.

Parameters:
UNIT_CYCLES, 56, clock cycles per NEC timing unit U (560 ns at a 10 ns clk, sim-scaled; must be >= 2)
CARRIER_HALF, 7, clock cycles per carrier half-period (used only with IR_CARRIER_EN; must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to transmit data_in; sampled only in IDLE
data_in  input  32  frame payload, latched on the accepted start
ir_out  output  1  IR waveform; 1 = space/idle, 0 = mark
busy  output  1  high from the accepted start until frame end
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (synchronous, active-high): ir_out=1, busy=0, done=0, state=IDLE, all counters cleared. Reset takes effect on the next edge, including mid-frame; the frame is aborted and no done pulse is issued.
- FSM states and durations:
  - IDLE: ir_out=1, no duration.
  - LEAD_MARK: 16U, ir_out=0.
  - LEAD_SPACE: 8U, ir_out=1.
  - BIT_MARK: 1U, ir_out=0.
  - BIT_SPACE: 1U for a 0 bit, 3U for a 1 bit, ir_out=1.
  - STOP_MARK: 1U, ir_out=0.
  - Transitions: IDLE -> LEAD_MARK -> LEAD_SPACE -> (BIT_MARK -> BIT_SPACE) x32 -> STOP_MARK -> IDLE.
- Start acceptance: start=1 at an edge while in IDLE latches data_in into a shift register. At that same edge the FSM enters LEAD_MARK and ir_out=0, busy=1 are registered. There is no cycle of latency beyond the register.
- Start while busy: ignored, and data_in is not resampled.
- Bit order: LSB first, so data_in[0] is the first bit after the leader. The shift register shifts right once per completed BIT_SPACE.
- Timing is exact: each state holds its output for exactly n*UNIT_CYCLES clocks. A single down-counter is reloaded on every state entry. A 5-bit bit counter runs 0..31; STOP_MARK follows the BIT_SPACE of bit 31.
- Frame end: on the edge that ends STOP_MARK the following are registered together: ir_out=1, busy=0, done=1 for exactly one cycle.
- Back-to-back: start high in that same cycle (done=1, state IDLE) is accepted at the next edge. The minimum idle gap is one cycle.
- Frame length in U: 25 + 2*(number of zeros) + 4*(number of ones). Range 89U (all zeros) to 153U (all ones).

Optional Feature:
- Macro: IR_CARRIER_EN.
- Defined: during every mark state ir_out toggles every CARRIER_HALF cycles instead of holding 0.
  - The carrier phase counter restarts at each mark entry, and the first half-period is 0.
  - Spaces and IDLE stay at a solid 1.
  - Mark and space durations are unchanged.
  - The final mark edge returns ir_out to 1 regardless of carrier phase.
- Not defined: marks are solid 0, no carrier logic is synthesised, and CARRIER_HALF is unused.

Test Plan:
- Reset: hold reset 10 cycles with start=1 -> ir_out=1, busy=0, done=0 throughout; no frame starts until reset drops.
- Frame 32'h0000_0001: ir_out low 896 cycles, high 448, then bit0 low 56 / high 168, then 31 zeros of low 56 / high 56 each, stop low 56 -> done pulses once, total busy 89U+2U = 5096 cycles.
- Frame 32'hCC33_55AA: measure every mark/space width -> marks = 56, spaces 56/168 matching LSB-first bits; loopback into ir_decoder yields data_out=32'hCC33_55AA with data_valid.
- Start during busy with different data_in -> ignored, current frame unchanged; start held in the done cycle -> second frame begins one edge later, gap = 1 cycle.
- Reset asserted mid LEAD_SPACE and mid bit 17 -> ir_out=1, busy=0 on next edge, no done; a new start afterwards produces a complete correct frame.
- IR_CARRIER_EN defined, CARRIER_HALF=7: each mark is a 14-cycle-period square wave starting low; envelope widths identical to the non-carrier build; spaces solid 1.
